mod_dec_shifter: RTL
====================

MOD_DEC_SHIFTER -- requirements
Module: mod_dec_shifter

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning bytes per AES state (4x4, row-major, index = row*4+col); only 16 is legal.
REQ-002 The block SHALL have parameter W, default 8, meaning byte width in bits; only 8 is legal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous abort of the current block.
REQ-006 The block SHALL have port inp_shf, input, W bits: serial input byte, state order 0..15.
REQ-007 The block SHALL have port wr_en, input, 1 bit: input byte valid.
REQ-008 The block SHALL have port in_rdy, output, 1 bit: the block can accept a byte.
REQ-009 The block SHALL have port outp_shf, output, W bits: serial InvShiftRows output byte.
REQ-010 The block SHALL have port out_valid, output, 1 bit: outp_shf is valid.
REQ-011 The block SHALL have port out_rdy, input, 1 bit: downstream accepts the byte.
REQ-012 The block SHALL have port out_last, output, 1 bit: high with out_valid on output byte 15.
REQ-013 The block SHALL have port blk_done, output, 1 bit: one-cycle pulse in the cycle after byte 15 is accepted downstream.

Function
REQ-014 The block SHALL implement a two-state FSM, FILL and DRAIN, with a 4-bit in_cnt and a 4-bit out_cnt.
REQ-015 In FILL, in_rdy SHALL be 1 and out_valid SHALL be 0.
REQ-016 In FILL, a byte SHALL be accepted when wr_en is 1; it is written to buf[in_cnt] and in_cnt increments.
REQ-017 In FILL, wr_en=1 while in_rdy=0 SHALL be ignored, with no state change.
REQ-018 Acceptance of the byte at in_cnt=15 SHALL wrap in_cnt to 0 and move the FSM to DRAIN on the next edge.
REQ-019 In DRAIN, in_rdy SHALL be 0, out_valid SHALL be 1, and outp_shf SHALL equal inv[out_cnt], where inv[r*4+c] = buf[r*4 + ((c - r) mod 4)], i.e. row r rotated right by r.
REQ-020 In DRAIN, a handshake SHALL be out_valid and out_rdy; each handshake increments out_cnt.
REQ-021 The handshake at out_cnt=15 SHALL wrap out_cnt to 0, return the FSM to FILL, and pulse blk_done for the next cycle.
REQ-022 While out_valid=1 and out_rdy=0, outp_shf and out_last SHALL hold stable.
REQ-023 Latency SHALL be 1 cycle: the first output byte is valid in the cycle after byte 15 is accepted.
REQ-024 Sustained throughput SHALL be 16 bytes in plus 16 bytes out per block; there is no fill/drain overlap.
REQ-025 outp_shf SHALL be 0 whenever out_valid=0.
REQ-026 flush=1 SHALL, on the next edge, zero in_cnt and out_cnt, force FILL, and suppress blk_done; buffer contents are don't-care.
REQ-027 If resetn and flush are asserted together, resetn SHALL take priority; the result is identical either way.

Reset
REQ-028 While resetn=1, the block SHALL on each edge set state=FILL, in_cnt=0, out_cnt=0, all buf bytes=0, and blk_done=0.
REQ-029 Outputs SHALL be in_rdy=0 while resetn is asserted and in_rdy=1 in the first cycle after it is released.
REQ-030 Outputs SHALL be out_valid=0, outp_shf=0 and out_last=0 at and after reset.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial block; no blk_done is produced for it.

Structure
REQ-032 Shared package aes_pkg SHALL hold: N_BYTES=16, BYTE_W=8, the dec_shf_state_t enum (FILL, DRAIN), and the inverse-row-rotation index function.
REQ-033 The inverse permutation SHALL be a combinational sub-module, mod_dec_invperm (16 bytes in, 16 bytes out); the FSM, counters and buffer stay in mod_dec_shifter.

Verification
REQ-034 Bench SHALL check the basic block: bytes 00..0F with wr_en continuous and out_rdy=1 -> out 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C; out_last on 0C; blk_done one cycle later.
REQ-035 Bench SHALL check the encrypt/decrypt round-trip: random 16 bytes through the encryption shift stage, then this block -> output equals the original bytes.
REQ-036 Bench SHALL check output backpressure: out_rdy low for 3 cycles at out_cnt=5 -> outp_shf=04 held stable, out_cnt unchanged, then the sequence resumes.
REQ-037 Bench SHALL check input gaps: wr_en toggled 1/0 over bytes 00..0F -> same output as REQ-034; in_rdy=0 throughout DRAIN.
REQ-038 Bench SHALL check flush mid-fill: flush after 7 bytes, then 16 new bytes 10..1F -> out 10 11 12 13 17 14 15 16 1A 1B 18 19 1D 1E 1F 1C.
REQ-039 Bench SHALL check reset mid-drain: resetn at out_cnt=9 -> in_rdy=0 and out_valid=0 during reset, in_rdy=1 after release, no blk_done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt-side byte shifter: sizes, FSM
// state type and the InvShiftRows source-index helper.
package aes_pkg;

  localparam int unsigned N_BYTES = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } dec_shf_state_t;

  // Output index r*4+c takes buffer index r*4 + ((c - r) mod 4); the 2-bit
  // subtraction supplies the mod 4 wrap.
  function automatic logic [3:0] inv_src_idx(input logic [3:0] idx);
    logic [1:0] r;
    r = idx[3:2];
    return {r, idx[1:0] - r};
  endfunction

endpackage

// File: rtl/mod_dec_invperm.sv
// Combinational InvShiftRows permutation of a row-major 4x4 byte state:
// row r is rotated right by r positions.
module mod_dec_invperm
  import aes_pkg::*;
#(
  parameter int unsigned N = N_BYTES,
  parameter int unsigned W = BYTE_W
) (
  input  logic [N-1:0][W-1:0] din_i,
  output logic [N-1:0][W-1:0] dout_o
);

  for (genvar i = 0; i < N; i++) begin : g_perm
    assign dout_o[i] = din_i[inv_src_idx(4'(i))];
  end

endmodule

// File: rtl/mod_dec_shifter.sv
// Serial InvShiftRows stage: collects 16 state bytes, then streams them back
// out in inverse-shifted order with valid/ready backpressure.
module mod_dec_shifter
  import aes_pkg::*;
#(
  parameter int unsigned N = N_BYTES,
  parameter int unsigned W = BYTE_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic [W-1:0] inp_shf,
  input  logic         wr_en,
  output logic         in_rdy,
  output logic [W-1:0] outp_shf,
  output logic         out_valid,
  input  logic         out_rdy,
  output logic         out_last,
  output logic         blk_done
);

  localparam int unsigned CW = $clog2(N);

  dec_shf_state_t       state_q, state_d;
  logic [CW-1:0]        in_cnt_q, in_cnt_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [N-1:0][W-1:0]  mem_q, mem_d;
  logic                 blk_done_q, blk_done_d;
  logic [N-1:0][W-1:0]  inv_w;

  mod_dec_invperm #(.N(N), .W(W)) u_invperm (
    .din_i  (mem_q),
    .dout_o (inv_w)
  );

  // Handshake outputs are gated by reset so they read idle while it is held.
  assign in_rdy    = (state_q == FILL) && !resetn;
  assign out_valid = (state_q == DRAIN) && !resetn;
  assign outp_shf  = out_valid ? inv_w[out_cnt_q] : '0;
  assign out_last  = out_valid && (out_cnt_q == CW'(N - 1));
  assign blk_done  = blk_done_q;

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    mem_d      = mem_q;
    blk_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          mem_d[in_cnt_q] = inp_shf;
          in_cnt_d        = in_cnt_q + 1'b1;
          if (in_cnt_q == CW'(N - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_rdy) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == CW'(N - 1)) begin
            state_d    = FILL;
            blk_done_d = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    if (flush) begin
      state_d    = FILL;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      blk_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= FILL;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      mem_q      <= '0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      mem_q      <= mem_d;
      blk_done_q <= blk_done_d;
    end
  end

endmodule
